imem_loader: RTL and testbench

Byte-stream loader that fills the Gold processor's 512 x 32-bit instruction memory before or between program runs. It accepts bytes over a valid/ready handshake, packs each group of four into a 32-bit instruction word, and drives the instruction memory's write port at consecutive addresses. It sits between the off-chip/testbench boot channel and the imem write side. While loading, it holds the core in reset through `cpuHold`.

---
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader for the 512 x 32-bit instruction memory.
// Accepts bytes over a valid/ready handshake and packs four of them into one
// word, most-significant byte first. It writes each word to consecutive,
// wrapping imem addresses. While a session runs, the core is held in reset.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               begin a session (only honoured in IDLE)
//   baseAddr[0:8]       first word address, sampled on an accepted start
//   wordCount[0:9]      words to load (clamped to DEPTH), sampled on start
//   inValid, inData     byte stream source
//   inReady             byte accepted this cycle when inValid is also high
//   memWrEn, memAddr,   imem write port; memAddr and memDataIn hold their
//   memDataIn           values between writes
//   busy, cpuHold       session in progress (RECV/WRITE)
//   done                one-cycle end-of-session pulse
module imem_loader #(
  parameter int unsigned DEPTH = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [0:8]  baseAddr,
  input  logic [0:9]  wordCount,
  input  logic        inValid,
  input  logic [0:7]  inData,
  output logic        inReady,
  output logic        memWrEn,
  output logic [0:8]  memAddr,
  output logic [0:31] memDataIn,
  output logic        busy,
  output logic        done,
  output logic        cpuHold
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} stateT;

  stateT       state;
  stateT       nextState;
  logic [0:8]  addrReg;
  logic [0:9]  remaining;
  logic [1:0]  byteIdx;
  logic [0:23] wordBuf;
  logic        xfer;

  assign xfer = (state == RECV) && inValid;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (start) nextState = (wordCount == '0) ? DONE : RECV;
      RECV:  if (xfer && byteIdx == 2'd3) nextState = WRITE;
      WRITE: nextState = (remaining == 10'd1) ? DONE : RECV;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs depend on the registered state only
  always_comb begin
    inReady = (state == RECV);
    memWrEn = (state == WRITE);
    busy    = (state == RECV) || (state == WRITE);
    done    = (state == DONE);
    cpuHold = busy;
  end

  // Datapath. The first three bytes are shifted through wordBuf. The fourth
  // byte goes straight into the memDataIn register together with them. This
  // keeps memDataIn and memAddr stable outside the WRITE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addrReg   <= '0;
      remaining <= '0;
      byteIdx   <= '0;
      wordBuf   <= '0;
      memAddr   <= '0;
      memDataIn <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addrReg   <= baseAddr;
            remaining <= (wordCount > 10'(DEPTH)) ? 10'(DEPTH) : wordCount;
            byteIdx   <= '0;
          end
        end
        RECV: begin
          if (xfer) begin
            byteIdx <= byteIdx + 2'd1;
            if (byteIdx == 2'd3) begin
              memDataIn <= {wordBuf, inData};
              memAddr   <= addrReg;
            end else begin
              wordBuf <= {wordBuf[8:23], inData};
            end
          end
        end
        WRITE: begin
          addrReg   <= addrReg + 9'd1;
          remaining <= remaining - 10'd1;
          byteIdx   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. The expected writes are computed from
// the byte list and the base address: word i goes to (base+i) mod 512 and
// holds bytes 4i..4i+3 packed MSB first.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [0:8]  baseAddr = '0;
  logic [0:9]  wordCount = '0;
  logic        inValid = 1'b0;
  logic [0:7]  inData = '0;
  logic        inReady;
  logic        memWrEn;
  logic [0:8]  memAddr;
  logic [0:31] memDataIn;
  logic        busy;
  logic        done;
  logic        cpuHold;

  imem_loader #(.DEPTH(512)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .baseAddr(baseAddr),
    .wordCount(wordCount), .inValid(inValid), .inData(inData),
    .inReady(inReady), .memWrEn(memWrEn), .memAddr(memAddr),
    .memDataIn(memDataIn), .busy(busy), .done(done), .cpuHold(cpuHold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int startCyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation of the write port and the status outputs
  logic [8:0]  wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];
  int doneCnt = 0, doneCyc = -1, busyCnt = 0, readyInWrite = 0, holdBad = 0;

  always @(negedge clk) begin
    if (memWrEn === 1'b1) begin
      wrAddr.push_back(memAddr);
      wrData.push_back(memDataIn);
      wrCyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      doneCnt++;
      doneCyc = cyc;
    end
    if (busy === 1'b1) busyCnt++;
    if (memWrEn === 1'b1 && inReady === 1'b1) readyInWrite++;
    if (cpuHold !== busy) holdBad++;
  end

  task automatic clearMon();
    @(posedge clk);
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
    doneCnt = 0;
    doneCyc = -1;
    busyCnt = 0;
    readyInWrite = 0;
    holdBad = 0;
  endtask

  task automatic startSession(input int base, input int cnt);
    @(negedge clk);
    start     = 1'b1;
    baseAddr  = 9'(base);
    wordCount = 10'(cnt);
    startCyc  = cyc;
    @(negedge clk);
    start     = 1'b0;
    baseAddr  = 9'($urandom);
    wordCount = 10'($urandom);
  endtask

  // Offers bytes with random gaps; a byte counts as sent only when
  // inValid and inReady are both high before the rising edge.
  task automatic streamBytes(input logic [7:0] q[$], input int gapPct,
                             input int pulseAt, input int budget);
    int idx = 0;
    int n = 0;
    while (idx < q.size() && n < budget) begin
      start = (n == pulseAt);
      if (start) begin
        baseAddr  = 9'd7;
        wordCount = 10'd1;
      end
      if (int'($urandom_range(99)) < gapPct) begin
        inValid = 1'b0;
        inData  = 8'($urandom);
      end else begin
        inValid = 1'b1;
        inData  = q[idx];
      end
      if (inValid && inReady) idx++;
      @(negedge clk);
      n++;
    end
    inValid = 1'b0;
    start   = 1'b0;
    total++;
    if (idx != q.size()) begin
      bad++;
      $display("FAIL stream_timeout sent=%0d required=%0d", idx, q.size());
    end
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_timeout done=%b required=1", done);
    end
  endtask

  task automatic makeBytes(input int n, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  task automatic checkWrites(input string name, input int base,
                             input logic [7:0] q[$], input int nWords);
    total++;
    if (wrAddr.size() != nWords) begin
      bad++;
      $display("FAIL %s_count got=%0d exp=%0d", name, wrAddr.size(), nWords);
    end
    for (int i = 0; i < nWords && i < wrAddr.size(); i++) begin
      logic [8:0]  expA;
      logic [31:0] expD;
      expA = 9'((base + i) % 512);
      expD = {q[4*i], q[4*i+1], q[4*i+2], q[4*i+3]};
      total++;
      if (wrAddr[i] !== expA || wrData[i] !== expD) begin
        bad++;
        $display("FAIL %s_word%0d got=%0d/%h exp=%0d/%h", name, i,
                 wrAddr[i], wrData[i], expA, expD);
      end
    end
  endtask

  task automatic checkIdleOutputs(input string name);
    total++;
    if ({inReady, memWrEn, busy, done, cpuHold} !== 5'b0 ||
        memAddr !== 9'd0 || memDataIn !== 32'd0) begin
      bad++;
      $display("FAIL %s got=%b%b%b%b%b addr=%0d data=%h exp=00000 addr=0 data=0",
               name, inReady, memWrEn, busy, done, cpuHold, memAddr, memDataIn);
    end
  endtask

  task automatic test_reset();
    logic [7:0] q[$];
    #2 reset_n = 1'b0;
    #1 checkIdleOutputs("reset_initial");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clearMon();
    makeBytes(6, q);
    startSession(3, 2);
    streamBytes(q, 0, -1, 100);
    total++;
    if (wrAddr.size() != 1 || inReady !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre writes=%0d inReady=%b exp=1/1", wrAddr.size(), inReady);
    end
    #2 reset_n = 1'b0;
    #1 checkIdleOutputs("reset_mid_recv");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (inReady !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_after inReady=%b busy=%b exp=0/0", inReady, busy);
    end
    total++;
    if (doneCnt != 0) begin
      bad++;
      $display("FAIL reset_no_done got=%0d exp=0", doneCnt);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] q[$];
    q = '{8'h12, 8'h34, 8'h56, 8'h78};
    clearMon();
    startSession(5, 1);
    streamBytes(q, 0, -1, 50);
    waitDone(20);
    @(negedge clk);
    checkWrites("single", 5, q, 1);
    total++;
    if (busyCnt != 5) begin
      bad++;
      $display("FAIL single_busy_cycles got=%0d exp=5", busyCnt);
    end
    total++;
    if (wrCyc.size() != 1 || wrCyc[0] != startCyc + 5) begin
      bad++;
      $display("FAIL single_write_cycle got=%0d exp=%0d",
               (wrCyc.size() > 0) ? wrCyc[0] - startCyc : -1, 5);
    end
    total++;
    if (doneCnt != 1 || doneCyc != startCyc + 6) begin
      bad++;
      $display("FAIL single_done got=%0d@%0d exp=1@6", doneCnt, doneCyc - startCyc);
    end
  endtask

  task automatic test_wrap_stalls();
    logic [7:0] q[$];
    makeBytes(12, q);
    clearMon();
    startSession(510, 3);
    streamBytes(q, 40, -1, 500);
    waitDone(20);
    @(negedge clk);
    checkWrites("wrap", 510, q, 3);
    total++;
    if (readyInWrite != 0 || holdBad != 0) begin
      bad++;
      $display("FAIL wrap_ready_in_write got=%0d/%0d exp=0/0", readyInWrite, holdBad);
    end
  endtask

  task automatic test_zero_count();
    clearMon();
    startSession(40, 0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_done_next done=%b busy=%b exp=1/0", done, busy);
    end
    repeat (4) @(negedge clk);
    total++;
    if (wrAddr.size() != 0 || busyCnt != 0 || doneCnt != 1) begin
      bad++;
      $display("FAIL zero_activity writes=%0d busy=%0d done=%0d exp=0/0/1",
               wrAddr.size(), busyCnt, doneCnt);
    end
  endtask

  task automatic test_clamp();
    logic [7:0] q[$];
    int base;
    base = int'($urandom_range(511));
    makeBytes(2048, q);
    clearMon();
    startSession(base, 700);
    streamBytes(q, 10, 300, 10000);
    waitDone(20);
    repeat (10) @(negedge clk);
    checkWrites("clamp", base, q, 512);
    total++;
    if (doneCnt != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clamp_single_done got=%0d busy=%b exp=1/0", doneCnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] q2[$];
    makeBytes(4, q);
    makeBytes(8, q2);
    clearMon();
    startSession(200, 1);
    streamBytes(q, 0, -1, 50);
    waitDone(20);
    clearMon();
    startSession(100, 2);
    total++;
    if (busy !== 1'b1 || inReady !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept busy=%b inReady=%b exp=1/1", busy, inReady);
    end
    streamBytes(q2, 20, -1, 200);
    waitDone(20);
    @(negedge clk);
    checkWrites("b2b", 100, q2, 2);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_wrap_stalls();
    test_zero_count();
    test_clamp();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
